axi_wr_burst_master: RTL and testbench
======================================

Name: axi_wr_burst_master

Overview:
Single-clock AXI4 write master, the parametrised successor of the user-to-AXI write path. It accepts one write request (start address, beat count up to 65535) plus a valid/ready data stream with byte strobes. It splits the request into INCR bursts capped at P_MAX_BURST_LEN beats that never cross a 4 KB boundary. It keeps up to P_MAX_OUTSTANDING bursts awaiting B responses and reports completion and error status per request.

Parameters:
P_AXI_DATA_WIDTH, 128, AXI data width in bits (32/64/128/256); BYTES = P_AXI_DATA_WIDTH/8
P_AXI_ADDR_WIDTH, 32, AXI address width
P_MAX_BURST_LEN, 256, maximum beats per burst (1..256)
P_MAX_OUTSTANDING, 4, maximum bursts issued but not yet answered on B (1..15)
P_AXI_ID, 0, constant 4-bit AWID value

Ports:
i_axi_clk  in  1  sole clock
i_rst  in  1  asynchronous, active-high reset
i_wr_req_valid  in  1  request valid
o_wr_req_ready  out  1  request accepted when high with valid
i_wr_req_addr  in  P_AXI_ADDR_WIDTH  start byte address; low log2(BYTES) bits forced to zero
i_wr_req_beats  in  16  total beats
i_wr_data  in  P_AXI_DATA_WIDTH  write data
i_wr_strb  in  BYTES  byte strobes
i_wr_data_valid  in  1  data valid
o_wr_data_ready  out  1  data accepted
o_wr_done  out  1  one-cycle pulse: request fully answered
o_wr_err  out  1  valid with o_wr_done: some BRESP != OKAY
o_busy  out  1  request in progress
o_axi_awid  out  4  = P_AXI_ID
o_axi_aw_addr  out  P_AXI_ADDR_WIDTH  burst address
o_axi_aw_length  out  8  beats-1
o_axi_awsize  out  3  log2(BYTES)
o_axi_awburst  out  2  2'b01 INCR
o_axi_aw_valid  out  1
i_axi_aw_ready  in  1
o_axi_w_data  out  P_AXI_DATA_WIDTH
o_axi_wstrb  out  BYTES
o_axi_w_last  out  1
o_axi_w_valid  out  1
i_axi_w_ready  in  1
i_axi_bid  in  4  ignored
i_axi_bresp  in  2
i_axi_bvalid  in  1
o_axi_bready  out  1  tied 1

Behaviour:
- Reset (async, any state): FSM to IDLE. All outputs 0 except constants (awid, awsize, awburst, bready). Counters and sticky error cleared. An in-flight burst is abandoned.
- States: IDLE, CALC, AW, W, DRAIN, DONE.
- IDLE: o_wr_req_ready=1. On handshake, register addr (aligned) and beats into cur_addr/remaining, clear sticky error, then go to CALC. beats=0 goes straight to DONE with no AXI traffic.
- CALC (1 cycle): to4k = (4096 - cur_addr[11:0]) / BYTES; burst = min(remaining, P_MAX_BURST_LEN, to4k). Register awaddr=cur_addr, awlen=burst-1. Go to AW.
- AW: o_axi_aw_valid=1 only while outstanding < P_MAX_OUTSTANDING, otherwise held low. aw_valid, addr and len stay stable until the handshake. Handshake -> W, with beat_cnt=0.
- W: combinational pass-through. o_axi_w_valid=i_wr_data_valid, o_wr_data_ready=i_axi_w_ready, data and strb forwarded. o_axi_w_last = (beat_cnt==awlen). Both channels are 0 outside W. On each W handshake beat_cnt++. On the last-beat handshake: cur_addr += burst*BYTES, remaining -= burst, then go to CALC if remaining!=0, else DRAIN.
- DRAIN: wait for outstanding==0, then go to DONE.
- DONE (1 cycle): o_wr_done=1, o_wr_err=sticky error; then go to IDLE.
- outstanding counter: +1 on AW handshake, -1 on B handshake; both in the same cycle leaves it unchanged. Any B handshake with bresp!=0 sets the sticky error.
- o_busy=1 in every state except IDLE.
- cur_addr wraps modulo 2^P_AXI_ADDR_WIDTH.

Test Plan:
1. Width 128, addr 0x1000, beats 16, B OKAY -> one AW (addr 0x1000, len 15, size 4); 16 W beats with wlast on the 16th; o_wr_done pulse with err=0.
2. addr 0x0F80, beats 20 -> AW0 addr 0x0F80 len 7; AW1 addr 0x1000 len 11; no burst crosses 0x1000.
3. addr 0x0, beats 600, MAX_BURST 256 -> AWs at 0x0000/0x1000/0x2000 with len 255/255/87; done only after the third B.
4. MAX_OUTSTANDING=2, MAX_BURST=16, beats 48, bvalid held low -> third aw_valid stays 0 until one B is returned; then it issues.
5. Second B carries bresp=2'b10 -> all bursts still complete; o_wr_done with o_wr_err=1. Next request with all-OKAY B -> err=0.
6. Random wready and data_valid gaps with 37 beats -> exactly 37 beats transferred in order. Separately: i_rst asserted mid-W -> all outputs at reset values the same cycle; FSM restarts in IDLE. beats=0 -> done pulse with no aw_valid.

Source files
------------

// File: rtl/axi_wr_burst_master.sv
// AXI4 write master: splits one user write request into INCR bursts that stay
// inside 4 KB pages, tracks outstanding B responses and reports completion.
module axi_wr_burst_master #(
    parameter int         P_AXI_DATA_WIDTH  = 128,
    parameter int         P_AXI_ADDR_WIDTH  = 32,
    parameter int         P_MAX_BURST_LEN   = 256,
    parameter int         P_MAX_OUTSTANDING = 4,
    parameter logic [3:0] P_AXI_ID          = 4'd0,
    localparam int        BYTES             = P_AXI_DATA_WIDTH / 8
) (
    input  logic                        i_axi_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_req_valid,
    output logic                        o_wr_req_ready,
    input  logic [P_AXI_ADDR_WIDTH-1:0] i_wr_req_addr,
    input  logic [15:0]                 i_wr_req_beats,
    input  logic [P_AXI_DATA_WIDTH-1:0] i_wr_data,
    input  logic [BYTES-1:0]            i_wr_strb,
    input  logic                        i_wr_data_valid,
    output logic                        o_wr_data_ready,
    output logic                        o_wr_done,
    output logic                        o_wr_err,
    output logic                        o_busy,
    output logic [3:0]                  o_axi_awid,
    output logic [P_AXI_ADDR_WIDTH-1:0] o_axi_aw_addr,
    output logic [7:0]                  o_axi_aw_length,
    output logic [2:0]                  o_axi_awsize,
    output logic [1:0]                  o_axi_awburst,
    output logic                        o_axi_aw_valid,
    input  logic                        i_axi_aw_ready,
    output logic [P_AXI_DATA_WIDTH-1:0] o_axi_w_data,
    output logic [BYTES-1:0]            o_axi_wstrb,
    output logic                        o_axi_w_last,
    output logic                        o_axi_w_valid,
    input  logic                        i_axi_w_ready,
    input  logic [3:0]                  i_axi_bid,
    input  logic [1:0]                  i_axi_bresp,
    input  logic                        i_axi_bvalid,
    output logic                        o_axi_bready
);
    localparam int SZ = $clog2(BYTES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_AW    = 3'd2;
    localparam logic [2:0] S_W     = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]                  state;
    logic [P_AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [15:0]                 remaining;
    logic [8:0]                  burst;
    logic [7:0]                  beat_cnt;
    logic [3:0]                  outstanding;
    logic                        err_sticky;

    logic        in_w;
    logic        req_hs, aw_hs, w_hs, b_hs, w_last_c;
    logic [12:0] to4k;
    logic [15:0] burst_calc;
    logic        unused_ok;

    assign unused_ok = ^{i_axi_bid, i_wr_req_addr[SZ-1:0]};

    assign in_w     = (state == S_W);
    assign req_hs   = (state == S_IDLE) && i_wr_req_valid;
    assign aw_hs    = o_axi_aw_valid && i_axi_aw_ready;
    assign w_hs     = o_axi_w_valid && i_axi_w_ready;
    assign b_hs     = i_axi_bvalid;
    assign w_last_c = (beat_cnt == o_axi_aw_length);

    // Beats left in the current 4 KB page; cur_addr is beat aligned so this is exact.
    always_comb begin
        to4k       = (13'h1000 - {1'b0, cur_addr[11:0]}) >> SZ;
        burst_calc = remaining;
        if (burst_calc > 16'(P_MAX_BURST_LEN)) burst_calc = 16'(P_MAX_BURST_LEN);
        if (burst_calc > {3'b0, to4k})         burst_calc = {3'b0, to4k};
    end

    assign o_wr_req_ready  = (state == S_IDLE) && !i_rst;
    assign o_busy          = (state != S_IDLE);
    assign o_wr_done       = (state == S_DONE);
    assign o_wr_err        = (state == S_DONE) && err_sticky;
    assign o_axi_aw_valid  = (state == S_AW) && (outstanding < 4'(P_MAX_OUTSTANDING));
    assign o_axi_w_valid   = in_w && i_wr_data_valid;
    assign o_wr_data_ready = in_w && i_axi_w_ready;
    assign o_axi_w_data    = in_w ? i_wr_data : '0;
    assign o_axi_wstrb     = in_w ? i_wr_strb : '0;
    assign o_axi_w_last    = in_w && w_last_c;
    assign o_axi_awid      = P_AXI_ID;
    assign o_axi_awsize    = 3'(SZ);
    assign o_axi_awburst   = 2'b01;
    assign o_axi_bready    = 1'b1;

    always_ff @(posedge i_axi_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= S_IDLE;
            cur_addr        <= '0;
            remaining       <= '0;
            burst           <= '0;
            beat_cnt        <= '0;
            o_axi_aw_addr   <= '0;
            o_axi_aw_length <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_hs) begin
                    cur_addr  <= {i_wr_req_addr[P_AXI_ADDR_WIDTH-1:SZ], {SZ{1'b0}}};
                    remaining <= i_wr_req_beats;
                    state     <= (i_wr_req_beats == 16'd0) ? S_DONE : S_CALC;
                end
                S_CALC: begin
                    burst           <= burst_calc[8:0];
                    o_axi_aw_addr   <= cur_addr;
                    o_axi_aw_length <= 8'(burst_calc - 16'd1);
                    state           <= S_AW;
                end
                S_AW: if (aw_hs) begin
                    beat_cnt <= '0;
                    state    <= S_W;
                end
                S_W: if (w_hs) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    if (w_last_c) begin
                        cur_addr  <= cur_addr + (P_AXI_ADDR_WIDTH'(burst) << SZ);
                        remaining <= remaining - 16'(burst);
                        state     <= (remaining == 16'(burst)) ? S_DRAIN : S_CALC;
                    end
                end
                S_DRAIN: if (outstanding == 4'd0) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outstanding bursts and sticky BRESP error; an AW and B together cancel out.
    always_ff @(posedge i_axi_clk or posedge i_rst) begin
        if (i_rst) begin
            outstanding <= '0;
            err_sticky  <= 1'b0;
        end else begin
            if (aw_hs && !b_hs)
                outstanding <= outstanding + 4'd1;
            else if (!aw_hs && b_hs && outstanding != 4'd0)
                outstanding <= outstanding - 4'd1;

            if (req_hs)
                err_sticky <= 1'b0;
            else if (b_hs && i_axi_bresp != 2'b00)
                err_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Randomised bench: AXI slave plus user data source, checked against a
// burst-list model built from 4 KB / max-length splitting rules.
module tb_axi_wr_burst_master;
    localparam int         DW    = 128;
    localparam int         AW    = 32;
    localparam int         BYTES = DW / 8;
    localparam int         MAXB  = 16;
    localparam int         MAXO  = 2;
    localparam logic [3:0] ID    = 4'h5;

    logic             i_axi_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_wr_req_valid = 1'b0;
    logic             o_wr_req_ready;
    logic [AW-1:0]    i_wr_req_addr = '0;
    logic [15:0]      i_wr_req_beats = '0;
    logic [DW-1:0]    i_wr_data = '0;
    logic [BYTES-1:0] i_wr_strb = '0;
    logic             i_wr_data_valid = 1'b0;
    logic             o_wr_data_ready, o_wr_done, o_wr_err, o_busy;
    logic [3:0]       o_axi_awid;
    logic [AW-1:0]    o_axi_aw_addr;
    logic [7:0]       o_axi_aw_length;
    logic [2:0]       o_axi_awsize;
    logic [1:0]       o_axi_awburst;
    logic             o_axi_aw_valid;
    logic             i_axi_aw_ready = 1'b0;
    logic [DW-1:0]    o_axi_w_data;
    logic [BYTES-1:0] o_axi_wstrb;
    logic             o_axi_w_last, o_axi_w_valid;
    logic             i_axi_w_ready = 1'b0;
    logic [3:0]       i_axi_bid = '0;
    logic [1:0]       i_axi_bresp = '0;
    logic             i_axi_bvalid = 1'b0;
    logic             o_axi_bready;

    axi_wr_burst_master #(
        .P_AXI_DATA_WIDTH(DW), .P_AXI_ADDR_WIDTH(AW), .P_MAX_BURST_LEN(MAXB),
        .P_MAX_OUTSTANDING(MAXO), .P_AXI_ID(ID)
    ) dut (
        .i_axi_clk(i_axi_clk), .i_rst(i_rst),
        .i_wr_req_valid(i_wr_req_valid), .o_wr_req_ready(o_wr_req_ready),
        .i_wr_req_addr(i_wr_req_addr), .i_wr_req_beats(i_wr_req_beats),
        .i_wr_data(i_wr_data), .i_wr_strb(i_wr_strb),
        .i_wr_data_valid(i_wr_data_valid), .o_wr_data_ready(o_wr_data_ready),
        .o_wr_done(o_wr_done), .o_wr_err(o_wr_err), .o_busy(o_busy),
        .o_axi_awid(o_axi_awid), .o_axi_aw_addr(o_axi_aw_addr),
        .o_axi_aw_length(o_axi_aw_length), .o_axi_awsize(o_axi_awsize),
        .o_axi_awburst(o_axi_awburst), .o_axi_aw_valid(o_axi_aw_valid),
        .i_axi_aw_ready(i_axi_aw_ready), .o_axi_w_data(o_axi_w_data),
        .o_axi_wstrb(o_axi_wstrb), .o_axi_w_last(o_axi_w_last),
        .o_axi_w_valid(o_axi_w_valid), .i_axi_w_ready(i_axi_w_ready),
        .i_axi_bid(i_axi_bid), .i_axi_bresp(i_axi_bresp),
        .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready)
    );

    always #5 i_axi_clk = ~i_axi_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    aw_t              exp_aw[$];
    logic [7:0]       wlen_q[$];
    logic [DW-1:0]    dat_q[$];
    logic [BYTES-1:0] stb_q[$];
    logic [1:0]       b_q[$];
    int  tb_out = 0, w_idx = 0, burst_no = 0, err_idx = -1, hold_cyc = 0;
    int  aw_pct = 100, w_pct = 100, dv_pct = 100, b_pct = 100;
    bit  req_pend = 0, done_seen = 0, exp_err = 0, aw_wait = 0;
    logic [31:0] req_addr = '0, aw_prev_addr = '0;
    logic [15:0] req_beats = '0;
    logic [7:0]  aw_prev_len = '0;

    // One clock: drive at negedge, sample 3 ns later (2 ns before the posedge).
    task automatic tick();
        @(negedge i_axi_clk);
        i_wr_req_valid  = req_pend;
        i_wr_req_addr   = req_addr;
        i_wr_req_beats  = req_beats;
        i_axi_aw_ready  = ($urandom_range(99) < aw_pct);
        i_axi_w_ready   = ($urandom_range(99) < w_pct);
        i_wr_data_valid = (dat_q.size() > 0) && ($urandom_range(99) < dv_pct);
        i_wr_data       = (dat_q.size() > 0) ? dat_q[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
        i_wr_strb       = (stb_q.size() > 0) ? stb_q[0] : 16'($urandom());
        if (hold_cyc > 0) hold_cyc--;
        i_axi_bvalid    = (b_q.size() > 0) && (hold_cyc == 0) && ($urandom_range(99) < b_pct);
        i_axi_bresp     = i_axi_bvalid ? b_q[0] : 2'b00;
        i_axi_bid       = 4'($urandom());
        #3;
        if (req_pend && o_wr_req_ready) req_pend = 0;
        if (aw_wait) begin
            chk("aw_hold", o_axi_aw_valid, 1'b1);
            chk("aw_stable", {o_axi_aw_addr, o_axi_aw_length}, {aw_prev_addr, aw_prev_len});
        end
        if (tb_out >= MAXO) chk("aw_block", o_axi_aw_valid, 1'b0);
        if (o_axi_aw_valid) begin
            if (exp_aw.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
            else if (i_axi_aw_ready) begin
                chk("aw_addr", o_axi_aw_addr, exp_aw[0].addr);
                chk("aw_len", o_axi_aw_length, exp_aw[0].len);
                chk("aw_attr", {o_axi_awid, o_axi_awsize, o_axi_awburst}, {ID, 3'd4, 2'b01});
                wlen_q.push_back(exp_aw[0].len);
                exp_aw.pop_front();
                tb_out++;
            end
        end
        aw_wait      = o_axi_aw_valid && !i_axi_aw_ready;
        aw_prev_addr = o_axi_aw_addr;
        aw_prev_len  = o_axi_aw_length;
        chk("hs_match", i_wr_data_valid & o_wr_data_ready, o_axi_w_valid & i_axi_w_ready);
        if (o_axi_w_valid && i_axi_w_ready) begin
            if (dat_q.size() == 0 || wlen_q.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
            else begin
                chk("w_data", o_axi_w_data, dat_q[0]);
                chk("w_strb", o_axi_wstrb, stb_q[0]);
                chk("w_last", o_axi_w_last, w_idx == int'(wlen_q[0]));
                dat_q.pop_front();
                stb_q.pop_front();
                if (w_idx == int'(wlen_q[0])) begin
                    w_idx = 0;
                    wlen_q.pop_front();
                    b_q.push_back((burst_no == err_idx) ? 2'b10 : 2'b00);
                    burst_no++;
                end else w_idx++;
            end
        end
        if (i_axi_bvalid && o_axi_bready) begin
            b_q.pop_front();
            tb_out--;
        end
        if (o_wr_done) begin
            done_seen = 1;
            chk("done_err", o_wr_err, exp_err);
            chk("done_busy", o_busy, 1'b1);
            chk("done_aw_left", exp_aw.size(), 0);
            chk("done_data_left", dat_q.size(), 0);
            chk("done_b_left", b_q.size(), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge i_axi_clk);
        i_rst = 1'b1;
        #1;
        chk("rst_ctl", {o_wr_req_ready, o_wr_data_ready, o_wr_done, o_wr_err, o_busy,
                        o_axi_aw_valid, o_axi_w_valid, o_axi_w_last}, 8'h00);
        chk("rst_aw", {o_axi_aw_addr, o_axi_aw_length}, 40'h0);
        chk("rst_w", {o_axi_w_data, o_axi_wstrb}, 144'h0);
        chk("rst_const", {o_axi_awid, o_axi_awsize, o_axi_awburst, o_axi_bready}, {ID, 3'd4, 2'b01, 1'b1});
        i_wr_req_valid = 0; i_wr_data_valid = 0; i_axi_bvalid = 0; i_axi_aw_ready = 0; i_axi_w_ready = 0;
        exp_aw.delete(); wlen_q.delete(); dat_q.delete(); stb_q.delete(); b_q.delete();
        tb_out = 0; w_idx = 0; req_pend = 0; aw_wait = 0; hold_cyc = 0;
        repeat (2) @(negedge i_axi_clk);
        i_rst = 1'b0;
        #3;
        chk("rst_idle", {o_wr_req_ready, o_busy}, 2'b10);
    endtask

    // Reference: split [addr, addr+beats*BYTES) into page-bounded, length-capped bursts.
    task automatic setup_req(input logic [31:0] addr, input int beats, input int err_i, input int hold);
        logic [31:0] a;
        int rem, b, room;
        a = addr & ~32'(BYTES - 1);
        rem = beats;
        exp_aw.delete();
        while (rem > 0) begin
            room = (4096 - int'(a[11:0])) / BYTES;
            b = rem;
            if (b > MAXB) b = MAXB;
            if (b > room) b = room;
            exp_aw.push_back('{a, 8'(b - 1)});
            a = a + 32'(b * BYTES);
            rem -= b;
        end
        exp_err = (err_i >= 0) && (err_i < exp_aw.size());
        for (int i = 0; i < beats; i++) begin
            dat_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            stb_q.push_back(16'($urandom()));
        end
        err_idx = err_i; burst_no = 0; w_idx = 0; hold_cyc = hold; done_seen = 0;
        req_addr = addr; req_beats = 16'(beats); req_pend = 1;
    endtask

    task automatic run_req(input logic [31:0] addr, input int beats, input int err_i, input int hold);
        setup_req(addr, beats, err_i, hold);
        for (int c = 0; c < 20 * beats + hold + 300 && !done_seen; c++) tick();
        if (!done_seen) begin
            chk("timeout", 1'b0, 1'b1);
            do_reset();
        end else begin
            tick();
            chk("done_pulse", o_wr_done, 1'b0);
            chk("back_idle", {o_busy, o_wr_req_ready}, 2'b01);
        end
    endtask

    task automatic set_pct(input int a, input int w, input int d, input int b);
        aw_pct = a; w_pct = w; dv_pct = d; b_pct = b;
    endtask

    initial begin
        do_reset();
        set_pct(100, 100, 100, 100);
        run_req(32'h0000_1000, 16, -1, 0);
        run_req(32'h0000_0F80, 20, -1, 0);
        run_req(32'h0000_0000, 600, -1, 0);
        run_req(32'h0000_2000, 48, -1, 150);
        run_req(32'h0000_3000, 48, 1, 0);
        run_req(32'h0000_3000, 48, -1, 0);
        run_req(32'hFFFF_FFC0, 8, -1, 0);
        run_req(32'h0000_1F87, 5, -1, 0);
        set_pct(70, 60, 60, 50);
        run_req(32'h0000_4F00, 37, -1, 0);
        run_req(32'h0000_0500, 0, -1, 0);
        // Abort a request mid-burst and make sure the block restarts cleanly.
        set_pct(100, 100, 100, 100);
        setup_req(32'h0000_0800, 40, -1, 0);
        for (int c = 0; c < 500 && dat_q.size() > 35; c++) tick();
        chk("mid_w_reached", o_axi_w_valid | o_wr_data_ready, 1'b1);
        do_reset();
        run_req(32'h0000_0040, 10, -1, 0);
        for (int k = 0; k < 12; k++) begin
            set_pct($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30));
            run_req((k % 3 == 0) ? (32'h0000_1000 * $urandom_range(15) - 32'(16 * $urandom_range(20))) : $urandom(),
                    $urandom_range(100, 1), ($urandom_range(3) == 0) ? int'($urandom_range(4)) : -1,
                    ($urandom_range(3) == 0) ? 40 : 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
